clken_mgr: RTL



---
 rtl/clken_pkg.sv | 13 +
 rtl/clken_nco.sv | 28 ++
 rtl/clken_mgr.sv | 106 ++++++++++
 3 files changed

// File: rtl/clken_pkg.sv
// Shared types and constants for the clock-enable manager.
package clken_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int LOSS_CNT_W = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

endpackage

// File: rtl/clken_nco.sv
// One NCO channel: phase accumulator whose carry-out becomes a one-cycle enable strobe.
module clken_nco #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [ACC_W-1:0] inc,
  output logic             strobe
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};

  // Carry of the add is the strobe; the register keeps it exactly one cycle wide.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc    <= '0;
      strobe <= 1'b0;
    end else begin
      acc    <= sum[ACC_W-1:0];
      strobe <= sum[ACC_W];
    end
  end

endmodule

// File: rtl/clken_mgr.sv
// Lock-qualified clock-enable manager: PLL lock settling FSM plus NUM_CH NCO strobes.
// Optional CLKEN_RESYNC_EN adds a resync input that phase-aligns all channels.
module clken_mgr
  import clken_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ACC_W      = 24,
  parameter int SETTLE_CYC = 1024
) (
  input  logic                    clkin,
  input  logic                    reset,
  input  logic                    lock,
`ifdef CLKEN_RESYNC_EN
  input  logic                    resync,
`endif
  input  logic [NUM_CH*ACC_W-1:0] inc,
  output logic [NUM_CH-1:0]       clken,
  output logic                    rst_out,
  output logic                    ready,
  output logic [LOSS_CNT_W-1:0]   lock_loss_cnt
);

  localparam int CNT_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  logic             sync_p0;
  logic             lock_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             run_en;
  logic             loss_evt;
  logic             clr;

  // Stage boundary: two-flop synchronizer for the asynchronous lock input.
  always_ff @(posedge clkin) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync_p0 <= lock;
      lock_s  <= sync_p0;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) state <= WAIT_LOCK;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOCK: if (lock_s) state_nxt = SETTLE;
      SETTLE: begin
        if (!lock_s)              state_nxt = WAIT_LOCK;
        else if (cnt == CNT_LAST) state_nxt = RUN;
      end
      RUN:       if (!lock_s) state_nxt = WAIT_LOCK;
      default:   state_nxt = WAIT_LOCK;
    endcase
  end

  // Strobes stop on the same edge that leaves RUN, so a lock drop never leaks an enable.
  always_comb begin
    run_en   = (state == RUN) && lock_s;
    loss_evt = (state == RUN) && !lock_s;
  end

  always_ff @(posedge clkin) begin
    if (reset)                            cnt <= '0;
    else if (state != SETTLE)             cnt <= '0;
    else if (lock_s && (cnt != CNT_LAST)) cnt <= cnt + CNT_W'(1);
  end

  // Stage boundary: registered status outputs lag the state by one cycle.
  always_ff @(posedge clkin) begin
    if (reset) begin
      rst_out       <= 1'b1;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      rst_out <= (state != RUN);
      ready   <= (state == RUN);
      if (loss_evt && (lock_loss_cnt != LOSS_CNT_MAX))
        lock_loss_cnt <= lock_loss_cnt + LOSS_CNT_W'(1);
    end
  end

`ifdef CLKEN_RESYNC_EN
  assign clr = !run_en || resync;
`else
  assign clr = !run_en;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clken_nco #(.ACC_W(ACC_W)) u_nco (
      .clk    (clkin),
      .rst    (reset),
      .clr    (clr),
      .inc    (inc[k*ACC_W +: ACC_W]),
      .strobe (clken[k])
    );
  end

endmodule
